// File: rtl/thresh_presets_pkg.sv
// Shared types and helpers for the threshold/timer preset sequencer.
// Optional saturating step mode: define THRESH_PRESETS_SATURATE_EN.
package thresh_presets_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_OFFER  = 2'd2,
        ST_SETTLE = 2'd3
    } t_thrpset_state;

    localparam int DEFAULT_PRESET_VALUE = 65000;
    localparam int MAX_VEC_BITS         = 4096;
    localparam int MAX_VALUE_BITS       = 32;

    // Preset 0 sits in the most significant slice of the packed vector.
    function automatic logic [MAX_VALUE_BITS-1:0] preset_slice(
        input logic [MAX_VEC_BITS-1:0] vec,
        input int                      k,
        input int                      count,
        input int                      width
    );
        logic [MAX_VALUE_BITS-1:0] result;
        int                        base;
        result = '0;
        base   = (count - k - 1) * width;
        for (int b = 0; b < MAX_VALUE_BITS; b++) begin
            if (b < width) begin
                result[b] = vec[base + b];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/thresh_presets_sequencer_step.sv
// Next-index logic: wrap or saturate at the active range ends, reject dual presses.
// Saturating mode is selected with THRESH_PRESETS_SATURATE_EN.
module preset_step_index #(
    parameter int PARM_ACTIVE_COUNT = 10,
    parameter int PARM_IDX_WIDTH    = 4
) (
    input  logic [PARM_IDX_WIDTH-1:0] index,
    input  logic                      btn_next,
    input  logic                      btn_prev,
    output logic [PARM_IDX_WIDTH-1:0] next_index,
    output logic                      step
);

    localparam logic [PARM_IDX_WIDTH-1:0] LAST_INDEX = PARM_IDX_WIDTH'(PARM_ACTIVE_COUNT - 1);
    localparam logic [PARM_IDX_WIDTH-1:0] ONE        = PARM_IDX_WIDTH'(1);

    always_comb begin
        next_index = index;
        step       = 1'b0;
        if (btn_next && !btn_prev) begin
            if (index >= LAST_INDEX) begin
`ifdef THRESH_PRESETS_SATURATE_EN
                step       = 1'b0;
`else
                next_index = '0;
                step       = 1'b1;
`endif
            end else begin
                next_index = index + ONE;
                step       = 1'b1;
            end
        end else if (btn_prev && !btn_next) begin
            if (index == '0) begin
`ifdef THRESH_PRESETS_SATURATE_EN
                step       = 1'b0;
`else
                next_index = LAST_INDEX;
                step       = 1'b1;
`endif
            end else begin
                next_index = index - ONE;
                step       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thresh_presets_sequencer.sv
// Steps through N threshold/timer presets, offers each downstream via valid/ready, then settles.
// Define THRESH_PRESETS_SATURATE_EN to saturate at the range ends instead of wrapping.
module thresh_presets_sequencer
    import thresh_presets_pkg::*;
#(
    parameter int PARM_NUM_PRESETS    = 16,
    parameter int PARM_ACTIVE_COUNT   = 10,
    parameter int PARM_THRESH_WIDTH   = 16,
    parameter int PARM_TIMER_WIDTH    = 16,
    parameter int PARM_HOLDOFF_CYCLES = 20000,
    parameter logic [PARM_NUM_PRESETS*PARM_THRESH_WIDTH-1:0] parm_presets_config_thresholds =
        {PARM_NUM_PRESETS{PARM_THRESH_WIDTH'(DEFAULT_PRESET_VALUE)}},
    parameter logic [PARM_NUM_PRESETS*PARM_TIMER_WIDTH-1:0] parm_presets_config_timers =
        {PARM_NUM_PRESETS{PARM_TIMER_WIDTH'(DEFAULT_PRESET_VALUE)}},
    localparam int PARM_IDX_WIDTH = $clog2(PARM_NUM_PRESETS)
) (
    input  logic                         i_clk_20mhz,
    input  logic                         i_rstn_20mhz,
    input  logic                         i_btn_next,
    input  logic                         i_btn_prev,
    output logic [PARM_IDX_WIDTH-1:0]    o_value_enum,
    output logic [PARM_THRESH_WIDTH-1:0] o_value_thresh,
    output logic [PARM_TIMER_WIDTH-1:0]  o_value_timer,
    output logic                         o_cfg_valid,
    input  logic                         i_cfg_ready,
    output logic                         o_busy
);

    localparam int HOLD_W = (PARM_HOLDOFF_CYCLES > 1) ? $clog2(PARM_HOLDOFF_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        HOLD_W'((PARM_HOLDOFF_CYCLES > 0) ? PARM_HOLDOFF_CYCLES - 1 : 0);
    localparam logic [PARM_THRESH_WIDTH-1:0] THRESH_0 =
        parm_presets_config_thresholds[PARM_NUM_PRESETS*PARM_THRESH_WIDTH-1 -: PARM_THRESH_WIDTH];
    localparam logic [PARM_TIMER_WIDTH-1:0] TIMER_0 =
        parm_presets_config_timers[PARM_NUM_PRESETS*PARM_TIMER_WIDTH-1 -: PARM_TIMER_WIDTH];

    // Valid/ready: o_cfg_valid rises with stable values and holds them until an edge
    // with i_cfg_ready high; that edge is the transfer. Ready outside an offer is ignored.

    t_thrpset_state              state_q, state_d;
    logic [PARM_IDX_WIDTH-1:0]   index_q, index_d;
    logic [PARM_THRESH_WIDTH-1:0] thresh_q, thresh_d;
    logic [PARM_TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                        valid_q, valid_d;
    logic                        busy_q;
    logic [HOLD_W-1:0]           cnt_q, cnt_d;

    logic [PARM_IDX_WIDTH-1:0]   step_index;
    logic                        step;
    logic [MAX_VEC_BITS-1:0]     thresh_vec;
    logic [MAX_VEC_BITS-1:0]     timer_vec;
    logic [PARM_THRESH_WIDTH-1:0] sel_thresh;
    logic [PARM_TIMER_WIDTH-1:0] sel_timer;
    int                          sel;

    assign thresh_vec = MAX_VEC_BITS'(parm_presets_config_thresholds);
    assign timer_vec  = MAX_VEC_BITS'(parm_presets_config_timers);

    preset_step_index #(
        .PARM_ACTIVE_COUNT (PARM_ACTIVE_COUNT),
        .PARM_IDX_WIDTH    (PARM_IDX_WIDTH)
    ) u_step (
        .index      (index_q),
        .btn_next   (i_btn_next),
        .btn_prev   (i_btn_prev),
        .next_index (step_index),
        .step       (step)
    );

    // Indices past the stored presets fall back to preset 0.
    always_comb begin
        sel = int'(index_q);
        if (sel >= PARM_NUM_PRESETS) begin
            sel = 0;
        end
        sel_thresh = PARM_THRESH_WIDTH'(preset_slice(thresh_vec, sel, PARM_NUM_PRESETS, PARM_THRESH_WIDTH));
        sel_timer  = PARM_TIMER_WIDTH'(preset_slice(timer_vec, sel, PARM_NUM_PRESETS, PARM_TIMER_WIDTH));
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        thresh_d = thresh_q;
        timer_d  = timer_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (step) begin
                    index_d = step_index;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                thresh_d = sel_thresh;
                timer_d  = sel_timer;
                valid_d  = 1'b1;
                state_d  = ST_OFFER;
            end
            ST_OFFER: begin
                if (i_cfg_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = HOLD_LOAD;
                    state_d = (PARM_HOLDOFF_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q  <= ST_LOAD;
            index_q  <= '0;
            thresh_q <= THRESH_0;
            timer_q  <= TIMER_0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            thresh_q <= thresh_d;
            timer_q  <= timer_d;
            valid_q  <= valid_d;
            busy_q   <= (state_d != ST_IDLE);
            cnt_q    <= cnt_d;
        end
    end

    assign o_value_enum   = index_q;
    assign o_value_thresh = thresh_q;
    assign o_value_timer  = timer_q;
    assign o_cfg_valid    = valid_q;
    assign o_busy         = busy_q;

endmodule

// File: tb/tb_thresh_presets_sequencer.sv
// Directed bench for thresh_presets_sequencer: 16 presets, 10 active, holdoff 4,
// thresholds 100*k and timers 10*k. Honours THRESH_PRESETS_SATURATE_EN when defined.
module tb_thresh_presets_sequencer;

    localparam int N      = 16;
    localparam int ACTIVE = 10;
    localparam int W      = 16;
    localparam int HOLD   = 4;
    localparam int IDX_W  = $clog2(N);

    function automatic logic [N*W-1:0] build_vec(input int mul);
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v[(N-k)*W-1 -: W] = W'(k * mul);
        end
        return v;
    endfunction

    localparam logic [N*W-1:0] THR_VEC = build_vec(100);
    localparam logic [N*W-1:0] TMR_VEC = build_vec(10);

    logic             clk;
    logic             rstn;
    logic             btn_next;
    logic             btn_prev;
    logic [IDX_W-1:0] value_enum;
    logic [W-1:0]     value_thresh;
    logic [W-1:0]     value_timer;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cur    = 0;
    int exp_idx;
    logic stable;
    logic seen_valid;

    thresh_presets_sequencer #(
        .PARM_NUM_PRESETS               (N),
        .PARM_ACTIVE_COUNT              (ACTIVE),
        .PARM_THRESH_WIDTH              (W),
        .PARM_TIMER_WIDTH               (W),
        .PARM_HOLDOFF_CYCLES            (HOLD),
        .parm_presets_config_thresholds (THR_VEC),
        .parm_presets_config_timers     (TMR_VEC)
    ) dut (
        .i_clk_20mhz    (clk),
        .i_rstn_20mhz   (rstn),
        .i_btn_next     (btn_next),
        .i_btn_prev     (btn_prev),
        .o_value_enum   (value_enum),
        .o_value_thresh (value_thresh),
        .o_value_timer  (value_timer),
        .o_cfg_valid    (cfg_valid),
        .i_cfg_ready    (cfg_ready),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_next(input int idx);
`ifdef THRESH_PRESETS_SATURATE_EN
        return (idx == ACTIVE - 1) ? idx : idx + 1;
`else
        return (idx == ACTIVE - 1) ? 0 : idx + 1;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic nx, input logic pv);
        btn_next = nx;
        btn_prev = pv;
        @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Press, then expect LOAD for one cycle, the offer with new values, and the transfer.
    task automatic step_and_check(input logic nx, input logic pv, input int idx);
        pulse(nx, pv);
        check("latency_valid_low", 32'(cfg_valid), 32'd0);
        tick();
        check("offer_valid", 32'(cfg_valid), 32'd1);
        check("offer_enum", 32'(value_enum), 32'(idx));
        check("offer_thresh", 32'(value_thresh), 32'(idx * 100));
        check("offer_timer", 32'(value_timer), 32'(idx * 10));
        tick();
        check("transfer_valid_low", 32'(cfg_valid), 32'd0);
        wait_idle("step_idle");
    endtask

    initial begin
        rstn      = 1'b0;
        btn_next  = 1'b0;
        btn_prev  = 1'b0;
        cfg_ready = 1'b1;
        repeat (2) tick();
        check("rst_enum", 32'(value_enum), 32'd0);
        check("rst_valid", 32'(cfg_valid), 32'd0);
        check("rst_thresh", 32'(value_thresh), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Reset release: preset 0 offered once, idle after HOLD+2 edges.
        rstn = 1'b1;
        for (int c = 1; c <= HOLD + 2; c++) begin
            tick();
            if (c == 1) begin
                check("boot_valid", 32'(cfg_valid), 32'd1);
                check("boot_enum", 32'(value_enum), 32'd0);
            end
            if (c == 2) check("boot_valid_pulse", 32'(cfg_valid), 32'd0);
            if (c == HOLD + 1) check("boot_busy_settle", 32'(busy), 32'd1);
            if (c == HOLD + 2) check("boot_busy_idle", 32'(busy), 32'd0);
        end

`ifdef THRESH_PRESETS_SATURATE_EN
        for (int i = 1; i < ACTIVE; i++) begin
            cur = model_next(cur);
            step_and_check(1'b1, 1'b0, cur);
        end
        pulse(1'b1, 1'b0);
        seen_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen_valid = seen_valid | cfg_valid | busy;
            tick();
        end
        check("sat_next_quiet", 32'(seen_valid), 32'd0);
        check("sat_next_enum", 32'(value_enum), 32'(ACTIVE - 1));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        wait_idle("sat_reset_idle");
        cur = 0;
        pulse(1'b0, 1'b1);
        seen_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen_valid = seen_valid | cfg_valid | busy;
            tick();
        end
        check("sat_prev_quiet", 32'(seen_valid), 32'd0);
        check("sat_prev_enum", 32'(value_enum), 32'd0);
`else
        for (int i = 1; i <= ACTIVE; i++) begin
            cur = model_next(cur);
            step_and_check(1'b1, 1'b0, cur);
        end
        check("wrap_next_enum", 32'(value_enum), 32'd0);
        cur = ACTIVE - 1;
        step_and_check(1'b0, 1'b1, cur);
`endif

        // Downstream stalls: offer must hold and presses must be dropped.
        cfg_ready = 1'b0;
        exp_idx = model_next(cur);
        pulse(1'b1, 1'b0);
        tick();
        check("stall_valid", 32'(cfg_valid), 32'd1);
        check("stall_enum", 32'(value_enum), 32'(exp_idx));
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) btn_next = 1'b1;
            if (c == 20) btn_prev = 1'b1;
            if (c == 30) begin
                btn_next = 1'b1;
                btn_prev = 1'b1;
            end
            tick();
            btn_next = 1'b0;
            btn_prev = 1'b0;
            if (cfg_valid !== 1'b1 || value_enum !== IDX_W'(exp_idx) ||
                value_thresh !== W'(exp_idx * 100) || value_timer !== W'(exp_idx * 10) ||
                busy !== 1'b1) begin
                stable = 1'b0;
            end
        end
        check("stall_stable", 32'(stable), 32'd1);
        cfg_ready = 1'b1;
        tick();
        check("stall_release_valid", 32'(cfg_valid), 32'd0);
        check("stall_release_enum", 32'(value_enum), 32'(exp_idx));
        wait_idle("stall_idle");
        check("stall_final_enum", 32'(value_enum), 32'(exp_idx));
        cur = exp_idx;

        // Both buttons in the same cycle are rejected.
        pulse(1'b1, 1'b1);
        check("both_busy", 32'(busy), 32'd0);
        check("both_enum", 32'(value_enum), 32'(cur));
        repeat (3) tick();
        check("both_busy_later", 32'(busy), 32'd0);
        check("both_valid", 32'(cfg_valid), 32'd0);

        // Reset during holdoff.
        exp_idx = model_next(cur);
        pulse(1'b1, 1'b0);
        tick();
        tick();
        check("settle_busy", 32'(busy), 32'd1);
        check("settle_enum", 32'(value_enum), 32'(exp_idx));
        rstn = 1'b0;
        tick();
        check("rst_settle_enum", 32'(value_enum), 32'd0);
        check("rst_settle_valid", 32'(cfg_valid), 32'd0);
        check("rst_settle_thresh", 32'(value_thresh), 32'd0);
        check("rst_settle_timer", 32'(value_timer), 32'd0);
        rstn = 1'b1;
        tick();
        check("reoffer1_valid", 32'(cfg_valid), 32'd1);
        check("reoffer1_enum", 32'(value_enum), 32'd0);
        wait_idle("reoffer1_idle");
        cur = 0;

        // Reset while an offer is pending.
        cfg_ready = 1'b0;
        pulse(1'b1, 1'b0);
        tick();
        check("offer_pend_valid", 32'(cfg_valid), 32'd1);
        check("offer_pend_enum", 32'(value_enum), 32'd1);
        check("offer_pend_thresh", 32'(value_thresh), 32'd100);
        rstn = 1'b0;
        cfg_ready = 1'b1;
        tick();
        check("rst_offer_enum", 32'(value_enum), 32'd0);
        check("rst_offer_valid", 32'(cfg_valid), 32'd0);
        check("rst_offer_thresh", 32'(value_thresh), 32'd0);
        rstn = 1'b1;
        tick();
        check("reoffer2_valid", 32'(cfg_valid), 32'd1);
        check("reoffer2_enum", 32'(value_enum), 32'd0);
        tick();
        check("reoffer2_valid_low", 32'(cfg_valid), 32'd0);
        wait_idle("reoffer2_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/thresh_presets_sequencer.md
Name: thresh_presets_sequencer

Overview:
- Parametrised successor to the fixed 10-of-16 threshold preset selector. Holds N presets of (threshold, timer) pairs with configurable widths and an active-preset count.
- Steps forward or backward on debounced button pulses. Presents the selected values on registered outputs.
- Offers each new preset to the downstream accelerometer configuration FSM with a valid/ready handshake, then applies a settle holdoff before it accepts another button.
- Sits between the button debouncers and the ACL driver command sequencer.

Parameters:
- PARM_NUM_PRESETS, 16, number of stored presets; minimum 2.
- PARM_ACTIVE_COUNT, 10, presets reachable by stepping (indices 0..PARM_ACTIVE_COUNT-1). Range 1..PARM_NUM_PRESETS.
- PARM_THRESH_WIDTH, 16, threshold value width.
- PARM_TIMER_WIDTH, 16, timer value width.
- PARM_HOLDOFF_CYCLES, 20000, settle cycles after each handshake; 0 means no settle.
- parm_presets_config_thresholds, all 65000, packed PARM_NUM_PRESETS*PARM_THRESH_WIDTH vector. Preset 0 occupies the MSB slice.
- parm_presets_config_timers, all 65000, packed vector with the same layout.
- PARM_IDX_WIDTH, $clog2(PARM_NUM_PRESETS), localparam (derived, not overridable).

Ports:
- i_clk_20mhz, in, 1, 20 MHz system clock.
- i_rstn_20mhz, in, 1, synchronous active-low reset.
- i_btn_next, in, 1, single-cycle debounced pulse: advance the preset.
- i_btn_prev, in, 1, single-cycle debounced pulse: retreat the preset.
- o_value_enum, out, PARM_IDX_WIDTH, current preset index.
- o_value_thresh, out, PARM_THRESH_WIDTH, current threshold.
- o_value_timer, out, PARM_TIMER_WIDTH, current timer.
- o_cfg_valid, out, 1, new preset offered downstream.
- i_cfg_ready, in, 1, downstream accepts the preset.
- o_busy, out, 1, high when the FSM is not in ST_IDLE.

Behaviour:
- Reset (i_rstn_20mhz=0 at a clock edge):
  - index = 0; o_value_enum = 0; thresh/timer = preset 0 slices.
  - o_cfg_valid = 0; holdoff counter = 0; state = ST_LOAD.
  - Reset has priority over everything, including mid-handshake and mid-holdoff.
- All outputs are registered. Preset k slice is [(PARM_NUM_PRESETS-k)*W-1 -: W].
- ST_IDLE:
  - next only: index+1.
  - prev only: index-1.
  - Both or neither: no change and stay in ST_IDLE.
  - On any change, the index register updates at that edge and the state goes to ST_LOAD.
- Wrap rule: next at PARM_ACTIVE_COUNT-1 wraps to 0; prev at 0 wraps to PARM_ACTIVE_COUNT-1.
- ST_LOAD, one cycle:
  - o_value_* are loaded from the index; o_cfg_valid is set to 1; go to ST_OFFER.
  - Latency: a button in cycle t gives new values and o_cfg_valid=1 visible from cycle t+2.
- ST_OFFER:
  - o_value_* and o_cfg_valid are held stable until i_cfg_ready=1 at an edge.
  - At that edge: o_cfg_valid=0 and the counter loads PARM_HOLDOFF_CYCLES-1.
  - Next state is ST_SETTLE, or ST_IDLE if PARM_HOLDOFF_CYCLES=0.
  - i_cfg_ready while not offering is ignored.
- ST_SETTLE: the counter decrements to 0, then the state goes to ST_IDLE.
- Buttons are ignored (dropped, not queued) in ST_LOAD, ST_OFFER and ST_SETTLE.
- After reset, the first edge with reset released takes ST_LOAD to ST_OFFER, so preset 0 is always offered once.
- PARM_ACTIVE_COUNT=1: stepping keeps index 0 but still re-offers preset 0.
- Index arithmetic is done in PARM_IDX_WIDTH bits; an unreachable index decodes to preset 0.

Optional Feature:
- THRESH_PRESETS_SATURATE_EN.
- Defined:
  - next at PARM_ACTIVE_COUNT-1 and prev at 0 saturate instead of wrapping.
  - A saturated press causes no state change, no ST_LOAD and no handshake.
- Undefined: wrap-around as above.

Decomposition:
- Package thresh_presets_pkg holds:
  - the t_thrpset_state enum (ST_IDLE, ST_LOAD, ST_OFFER, ST_SETTLE);
  - default preset vectors;
  - a function that extracts slice k from a packed vector given count and width.
- One sub-module, preset_step_index: pure next-index logic (wrap/saturate, both-press rejection). It is unit-testable alone.

Test Plan:
- Reset release, ready tied 1:
  - o_cfg_valid pulses for 1 cycle after the first edge.
  - enum=0, thresh=preset0.
  - o_busy low after PARM_HOLDOFF_CYCLES+2 cycles.
- Preset vector with distinct values (thresh k = 100*k, timer k = 10*k), holdoff 4:
  - Step next ×10 with waits: enum goes 1..9 then wraps to 0.
  - At enum 9: thresh=900, timer=90.
- At enum 0, pulse prev: enum=9.
  - With THRESH_PRESETS_SATURATE_EN: enum stays 0 and o_cfg_valid never rises.
- Hold i_cfg_ready=0 for 50 cycles after a next pulse, and pulse next/prev during the wait:
  - Outputs and valid are stable, presses are dropped.
  - Release ready: one transfer, enum advanced by exactly 1.
- Assert next and prev in the same cycle in ST_IDLE: no index change, o_busy stays 0.
- Drop i_rstn_20mhz mid-ST_SETTLE and mid-ST_OFFER:
  - Next edge gives enum 0, valid 0.
  - After release, preset 0 is re-offered.
